// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: primary writeback always wins, secondary writes queue in a
// small FIFO and drain when the primary is idle. Reports pending-write status for two registers.
module writeback_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         priValid,
    input  logic [REG_BITS-1:0]          priReg,
    input  logic [WIDTH-1:0]             priData,
    input  logic                         secValid,
    output logic                         secReady,
    input  logic [REG_BITS-1:0]          secReg,
    input  logic [WIDTH-1:0]             secData,
    output logic                         regWrite,
    output logic [REG_BITS-1:0]          writeReg,
    output logic [WIDTH-1:0]             writeData,
    input  logic [REG_BITS-1:0]          queryReg1,
    input  logic [REG_BITS-1:0]          queryReg2,
    output logic                         busy1,
    output logic                         busy2,
    output logic [$clog2(DEPTH+1)-1:0]   secCount
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [REG_BITS-1:0] mem_reg_q  [DEPTH];
    logic [WIDTH-1:0]    mem_data_q [DEPTH];
    logic [PtrW-1:0]     wptr_q, rptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic                reg_write_q;
    logic [REG_BITS-1:0] write_reg_q;
    logic [WIDTH-1:0]    write_data_q;

    logic push, pop;

    assign secReady = (count_q < CntW'(DEPTH));
    // A reg-0 request completes its handshake but is dropped: writes to x0 are no-ops.
    assign push     = secValid && secReady && (secReg != '0);
    assign pop      = !priValid && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg_q[wptr_q]  <= secReg;
            mem_data_q[wptr_q] <= secData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (priValid) begin
                reg_write_q  <= (priReg != '0);
                write_reg_q  <= priReg;
                write_data_q <= priData;
            end else if (pop) begin
                reg_write_q  <= 1'b1;
                write_reg_q  <= mem_reg_q[rptr_q];
                write_data_q <= mem_data_q[rptr_q];
                rptr_q       <= rptr_q + PtrW'(1);
            end else begin
                reg_write_q <= 1'b0;
            end
        end
    end

    // An entry is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PtrW-1:0] offset;
        logic            occupied;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PtrW'(i) - rptr_q;
            occupied = (CntW'(offset) < count_q);
            if (occupied && (queryReg1 != '0) && (mem_reg_q[i] == queryReg1)) begin
                busy1 = 1'b1;
            end
            if (occupied && (queryReg2 != '0) && (mem_reg_q[i] == queryReg2)) begin
                busy2 = 1'b1;
            end
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign secCount  = count_q;

endmodule
